// File: rtl/ip_lookup_pkg.sv
// Shared types and constants for the IP lookup requester and its command FIFO.
package ip_lookup_pkg;

    localparam int IP_ADDR_W = 32;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic                 insert;
        logic [IP_ADDR_W-1:0] ip;
    } cmd_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/ip_lookup_requester_fifo.sv
// Synchronous command FIFO (cmd_t entries) with occupancy count; async active-high reset.
module ip_cmd_fifo
    import ip_lookup_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  cmd_t                   data_i,
    input  logic                   pop_i,
    output cmd_t                   data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ip_lookup_requester.sv
// Issues buffered insert/lookup commands to the IP hash controller and reports lookup verdicts.
// Optional statistics counters are enabled with `define IP_LOOKUP_STATS_EN.
module ip_lookup_requester #(
    parameter int IP_ADDR_W      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_insert_i,
    input  logic [IP_ADDR_W-1:0] cmd_ip_addr_i,
    output logic                 insert_val_o,
    output logic                 look_up_val_o,
    output logic [IP_ADDR_W-1:0] ip_addr_o,
    input  logic                 found_i,
    input  logic                 found_valid_i,
    output logic                 result_valid_o,
    output logic                 result_found_o,
    output logic                 result_timeout_o,
    output logic [IP_ADDR_W-1:0] result_ip_addr_o,
    output logic                 busy_o
`ifdef IP_LOOKUP_STATS_EN
    ,
    output logic [15:0]          stat_lookups_o,
    output logic [15:0]          stat_hits_o,
    output logic [15:0]          stat_timeouts_o
`endif
);

    import ip_lookup_pkg::*;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int                FCW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    cmd_t                 hold_q, hold_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 ins_q, ins_d;
    logic                 lu_q, lu_d;
    logic                 rv_q, rv_d;
    logic                 rf_q, rf_d;
    logic                 rt_q, rt_d;
    logic [IP_ADDR_W-1:0] raddr_q, raddr_d;

    cmd_t                 fifo_in, fifo_head;
    logic                 push, pop, fifo_full, fifo_empty;
    logic [FCW-1:0]       fifo_count, count_nxt;

    assign push    = cmd_valid_i && ready_q && !fifo_full;
    assign fifo_in = '{insert: cmd_insert_i, ip: cmd_ip_addr_i};

    ip_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ready is registered from the post-edge occupancy so it is exact in the following cycle.
    assign count_nxt = fifo_count + FCW'(push) - FCW'(pop);
    assign ready_d   = (count_nxt != FCW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        ins_d   = 1'b0;
        lu_d    = 1'b0;
        rv_d    = 1'b0;
        rf_d    = rf_q;
        rt_d    = rt_q;
        raddr_d = raddr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_head;
                    ins_d   = fifo_head.insert;
                    lu_d    = !fifo_head.insert;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = hold_q.insert ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (found_valid_i) begin
                    rv_d    = 1'b1;
                    rf_d    = found_i;
                    rt_d    = 1'b0;
                    raddr_d = hold_q.ip;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rv_d    = 1'b1;
                    rf_d    = 1'b0;
                    rt_d    = 1'b1;
                    raddr_d = hold_q.ip;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ins_q   <= 1'b0;
            lu_q    <= 1'b0;
            rv_q    <= 1'b0;
            rf_q    <= 1'b0;
            rt_q    <= 1'b0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ins_q   <= ins_d;
            lu_q    <= lu_d;
            rv_q    <= rv_d;
            rf_q    <= rf_d;
            rt_q    <= rt_d;
            raddr_q <= raddr_d;
        end
    end

    assign cmd_ready_o      = ready_q;
    assign insert_val_o     = ins_q;
    assign look_up_val_o    = lu_q;
    assign ip_addr_o        = hold_q.ip;
    assign result_valid_o   = rv_q;
    assign result_found_o   = rf_q;
    assign result_timeout_o = rt_q;
    assign result_ip_addr_o = raddr_q;
    assign busy_o           = (state_q != IDLE) || !fifo_empty;

`ifdef IP_LOOKUP_STATS_EN
    logic [STAT_W-1:0] lookups_q, lookups_d;
    logic [STAT_W-1:0] hits_q, hits_d;
    logic [STAT_W-1:0] timeouts_q, timeouts_d;

    always_comb begin
        lookups_d  = sat_inc(lookups_q, lu_q);
        hits_d     = sat_inc(hits_q, rv_q && rf_q);
        timeouts_d = sat_inc(timeouts_q, rv_q && rt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q  <= '0;
            hits_q     <= '0;
            timeouts_q <= '0;
        end else begin
            lookups_q  <= lookups_d;
            hits_q     <= hits_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign stat_lookups_o  = lookups_q;
    assign stat_hits_o     = hits_q;
    assign stat_timeouts_o = timeouts_q;
`endif

endmodule

// File: doc/ip_lookup_requester.md
Name: ip_lookup_requester

Overview:
Initiator side of the IP hash controller command interface. Accepts insert and lookup commands from the parser or config path through a valid/ready port and buffers them in a small FIFO. Issues them one at a time as single-cycle insert_val/look_up_val pulses, waits for the found/valid response on lookups (with a timeout), and emits a registered per-lookup verdict.

Parameters:
IP_ADDR_W, 32, width of IP address.
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
TIMEOUT_CYCLES, 64, max cycles in WAIT before declaring a timeout (>=2).

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  reset; asynchronous, active-high.
cmd_valid_i  in  1  command valid.
cmd_ready_o  out  1  FIFO not full.
cmd_insert_i  in  1  1 = insert, 0 = lookup.
cmd_ip_addr_i  in  IP_ADDR_W  address for the command.
insert_val_o  out  1  one-cycle insert strobe to hash controller.
look_up_val_o  out  1  one-cycle lookup strobe to hash controller.
ip_addr_o  out  IP_ADDR_W  address; valid while either strobe is high.
found_i  in  1  hash controller lookup result.
found_valid_i  in  1  qualifies found_i.
result_valid_o  out  1  one-cycle verdict strobe.
result_found_o  out  1  address present.
result_timeout_o  out  1  no response within TIMEOUT_CYCLES.
result_ip_addr_o  out  IP_ADDR_W  address the verdict refers to.
busy_o  out  1  FSM not in IDLE or FIFO non-empty.

Behaviour:
- Reset (async assert): all outputs 0, FIFO emptied, FSM in IDLE, timeout counter 0. cmd_ready_o=1 from the first cycle after reset deasserts.
- Command accept: on cmd_valid_i && cmd_ready_o. cmd_ready_o = !full, registered from the FIFO count. A command is never dropped.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if FIFO non-empty, pop the head into a holding register and go to ISSUE. The pop occurs in the same cycle as the decision.
- ISSUE (exactly one cycle): drive ip_addr_o from the holding register and pulse exactly one strobe.
  - Insert: insert_val_o=1, then go to IDLE. Fire-and-forget; no result is emitted.
  - Lookup: look_up_val_o=1, clear the counter, then go to WAIT.
- WAIT: the counter increments each cycle.
  - found_valid_i=1: next cycle result_valid_o=1, result_found_o=found_i, result_timeout_o=0, result_ip_addr_o=holding address. Then go to IDLE.
  - Else, counter reaches TIMEOUT_CYCLES-1: next cycle result_valid_o=1, result_found_o=0, result_timeout_o=1. Then go to IDLE.
  - Both conditions in the same cycle: the response wins.
- Strobes and result_valid_o are 0 in all other cycles. result_found_o, result_timeout_o and result_ip_addr_o hold their last value between verdicts.
- found_valid_i outside WAIT (late response after a timeout, or spurious) is ignored, with no result.
- Minimum spacing: an insert occupies 2 cycles (IDLE, ISSUE). A lookup occupies 3 cycles plus response latency.
- Simultaneous push and pop: allowed when not full. The count is unchanged.
- FIFO full: cmd_ready_o=0 until the next pop. A push attempted while full is not accepted.
- Counter width: $clog2(TIMEOUT_CYCLES)+1 bits. No wrap is possible.
- Reset mid-WAIT: the in-flight lookup is abandoned with no result. A later found_valid_i is ignored per the rule above.

Optional Feature:
IP_LOOKUP_STATS_EN
- Defined: adds outputs stat_lookups_o, stat_hits_o and stat_timeouts_o (16 bits each, saturating at 0xFFFF, reset to 0).
  - lookups increments on each look_up_val_o.
  - hits increments on each result with result_found_o=1.
  - timeouts increments on each result_timeout_o=1.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package ip_lookup_pkg:
  - typedef enum state_t {IDLE, ISSUE, WAIT};
  - typedef struct packed cmd_t {logic insert; logic [IP_ADDR_W-1:0] ip;}, with IP_ADDR_W as a package localparam defaulting to 32;
  - STAT_W=16.
- Sub-module ip_cmd_fifo: synchronous FIFO of cmd_t with push/pop/full/empty and async active-high reset. The requester instantiates it once.

Test Plan:
- Reset, then one lookup of 0xC0A80001 with hash response found=1 three cycles after the strobe -> look_up_val_o pulses once with ip_addr_o=0xC0A80001; result_valid_o one cycle after found_valid_i, with found=1, timeout=0, addr=0xC0A80001.
- Insert 0x0A000001 followed immediately by a lookup of 0x0A000001 -> insert_val_o pulse, then look_up_val_o pulse exactly 2 cycles later; exactly one result; no result for the insert.
- Lookup with found_valid_i never asserted, TIMEOUT_CYCLES=64 -> result_valid_o with found=0 and timeout=1 exactly 64 cycles after entering WAIT. A found_valid_i injected 5 cycles later produces no result.
- found_valid_i=1 with found_i=0 in the same cycle the counter hits 63 -> result found=0, timeout=0.
- Push 6 back-to-back lookups with FIFO_DEPTH=4 while the first is in WAIT -> cmd_ready_o drops after 4 are buffered; all 6 are issued in order; 6 results arrive in order.
- Assert rst during WAIT, deassert, then assert found_valid_i -> no result; outputs are 0; cmd_ready_o=1. With IP_LOOKUP_STATS_EN defined, the stat counters read 0.
